// File: rtl/isqrt_iter.sv
// Iterative restoring integer square root: floor(sqrt(radicand)) and exact remainder,
// BITS_PER_CYC root bits per clock. Optional rounding enabled by defining ISQRT_ROUND_EN.
module isqrt_iter #(
    parameter int unsigned IN_W         = 32,
    parameter int unsigned BITS_PER_CYC = 1,
    localparam int unsigned OUT_W       = IN_W / 2,
    localparam int unsigned ITER        = OUT_W / BITS_PER_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  radicand,
`ifdef ISQRT_ROUND_EN
    input  logic             round_en,
`endif
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] root,
    output logic [OUT_W:0]   rem,
    output logic             busy
);

    localparam int unsigned RW    = OUT_W + 2;
    localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    if ((IN_W % 2) != 0 || IN_W < 4) begin : g_bad_in_w
        $error("isqrt_iter: IN_W must be even and at least 4");
    end
    if (!(BITS_PER_CYC == 1 || BITS_PER_CYC == 2 || BITS_PER_CYC == 4) ||
        (OUT_W % BITS_PER_CYC) != 0) begin : g_bad_bpc
        $error("isqrt_iter: BITS_PER_CYC must be 1, 2 or 4 and divide IN_W/2");
    end

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q;
    logic [IN_W-1:0]  rad_q;
    logic [OUT_W-1:0] q_q;
    logic [RW-1:0]    r_q;
    logic [CNT_W-1:0] cnt_q;

    logic [IN_W-1:0]  step_rad;
    logic [OUT_W-1:0] step_q;
    logic [RW-1:0]    step_r;
    logic [RW-1:0]    r_try;
    logic [RW-1:0]    t_try;
    logic [OUT_W-1:0] root_val;

    // Unrolled restoring steps; r stays below 2^OUT_W before each shift, so no bits are lost.
    always_comb begin
        step_rad = rad_q;
        step_q   = q_q;
        step_r   = r_q;
        r_try    = '0;
        t_try    = '0;
        for (int i = 0; i < int'(BITS_PER_CYC); i++) begin
            r_try    = {step_r[RW-3:0], step_rad[IN_W-1 -: 2]};
            t_try    = {step_q, 2'b01};
            step_rad = step_rad << 2;
            if (r_try >= t_try) begin
                step_r = r_try - t_try;
                step_q = {step_q[OUT_W-2:0], 1'b1};
            end else begin
                step_r = r_try;
                step_q = {step_q[OUT_W-2:0], 1'b0};
            end
        end
    end

`ifdef ISQRT_ROUND_EN
    logic rnd_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rad_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
`ifdef ISQRT_ROUND_EN
            rnd_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        rad_q   <= radicand;
                        q_q     <= '0;
                        r_q     <= '0;
                        cnt_q   <= '0;
`ifdef ISQRT_ROUND_EN
                        rnd_q   <= round_en;
`endif
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    if (abort) begin
                        state_q <= StIdle;
                    end else begin
                        rad_q <= step_rad;
                        q_q   <= step_q;
                        r_q   <= step_r;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_CNT) state_q <= StDone;
                    end
                end
                StDone: begin
                    if (abort || out_ready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef ISQRT_ROUND_EN
    // Round up when the remainder exceeds root, saturating at all-ones.
    always_comb begin
        root_val = q_q;
        if (rnd_q && (r_q > {2'b00, q_q}) && (q_q != '1)) root_val = q_q + OUT_W'(1);
    end
`else
    assign root_val = q_q;
`endif

    logic unused_r_msb;
    assign unused_r_msb = r_q[RW-1];

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StDone);
    assign root      = out_valid ? root_val : '0;
    assign rem       = out_valid ? r_q[OUT_W:0] : '0;

endmodule

// File: tb/tb_isqrt_iter.sv
// Scoreboard bench for isqrt_iter: default 32-bit/1-bit-per-cycle instance plus a
// 16-bit/2-bits-per-cycle instance; rounding vectors run when ISQRT_ROUND_EN is defined.
module tb_isqrt_iter;

    typedef struct {
        logic [31:0] rad;
        logic [15:0] root;
        logic [16:0] rem;
        bit          rnd;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, abort, out_valid, out_ready, busy, round_en;
    logic [31:0] radicand;
    logic [15:0] root;
    logic [16:0] rem;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [15:0] radicand2;
    logic [7:0]  root2;
    logic [8:0]  rem2;

    exp_t q1[$];
    exp_t q2[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    isqrt_iter #(.IN_W(32), .BITS_PER_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .radicand(radicand),
`ifdef ISQRT_ROUND_EN
        .round_en(round_en),
`endif
        .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
        .root(root), .rem(rem), .busy(busy)
    );

    isqrt_iter #(.IN_W(16), .BITS_PER_CYC(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .radicand(radicand2),
`ifdef ISQRT_ROUND_EN
        .round_en(1'b0),
`endif
        .abort(1'b0), .out_valid(out_valid2), .out_ready(out_ready2),
        .root(root2), .rem(rem2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] isqrt_ref(input logic [31:0] x);
        longint unsigned lo = 0, hi = 65535, mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= longint'(x)) lo = mid;
            else hi = mid - 1;
        end
        return lo[15:0];
    endfunction

    // Monitors: pop on every accepted output, and require zeroed outputs while not valid.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_valid && out_ready) begin
                    if (q1.size() == 0) begin
                        check("dut1_unexpected_out", 64'(out_valid), 64'd0);
                    end else begin
                        e = q1.pop_front();
                        check("dut1_root", 64'(root), 64'(e.root));
                        check("dut1_rem", 64'(rem), 64'(e.rem));
                        if (!e.rnd) begin
                            check("dut1_invariant", 64'(root) * 64'(root) + 64'(rem),
                                  64'(e.rad));
                            check("dut1_rem_le_2root", 64'(rem <= 17'(root) * 17'd2), 64'd1);
                        end
                    end
                end else if (!out_valid) begin
                    check("dut1_idle_zero", {31'd0, root, rem}, 64'd0);
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid2 && out_ready2) begin
                if (q2.size() == 0) begin
                    check("dut2_unexpected_out", 64'(out_valid2), 64'd0);
                end else begin
                    e = q2.pop_front();
                    check("dut2_root", 64'(root2), 64'(e.root));
                    check("dut2_rem", 64'(rem2), 64'(e.rem));
                    check("dut2_invariant", 64'(root2) * 64'(root2) + 64'(rem2), 64'(e.rad));
                end
            end
        end
    end

    // Drive one operand on dut (called just after a posedge); hold>0 applies backpressure.
    task automatic run_op(input logic [31:0] rad, input logic [15:0] er, input logic [16:0] erem,
                          input bit rnd, input int hold);
        int g, n, bad;
        logic [15:0] h_root;
        logic [16:0] h_rem;
        g = 0;
        while (!in_ready && g < 200) begin
            @(posedge clk); #1; g++;
        end
        if (g == 200) check("dut1_in_ready_timeout", 64'(in_ready), 64'd1);
        out_ready = (hold == 0);
        radicand  = rad;
        round_en  = rnd;
        in_valid  = 1'b1;
        q1.push_back('{rad: rad, root: er, rem: erem, rnd: rnd});
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        bad = 0;
        while (!out_valid && n < 100) begin
            if (in_ready || !busy) bad++;
            @(posedge clk); #1; n++;
        end
        check("dut1_latency", 64'(n), 64'd16);
        check("dut1_in_ready_low_calc", 64'(bad), 64'd0);
        if (hold > 0) begin
            h_root = root;
            h_rem  = rem;
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1;
                radicand = 32'd49 + 32'(i);
                @(posedge clk); #1;
                in_valid = 1'b0;
                check("dut1_bp_valid", 64'(out_valid), 64'd1);
                check("dut1_bp_stable", {31'd0, root, rem}, {31'd0, h_root, h_rem});
                check("dut1_bp_in_ready", 64'(in_ready), 64'd0);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("dut1_consumed", 64'({out_valid, in_ready}), 64'b01);
    endtask

    task automatic run_op2(input logic [15:0] rad, input logic [7:0] er, input logic [8:0] erem);
        int n;
        radicand2 = rad;
        in_valid2 = 1'b1;
        q2.push_back('{rad: 32'(rad), root: 16'(er), rem: 17'(erem), rnd: 1'b0});
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        n = 0;
        while (!out_valid2 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("dut2_latency", 64'(n), 64'd4);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r32;
        logic [15:0] rr;
        rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1; round_en = 1'b0;
        radicand = '0; in_valid2 = 1'b0; out_ready2 = 1'b1; radicand2 = '0;
        #12;
        check("reset_outputs", {58'd0, in_ready, out_valid, busy, 1'b0, |root, |rem}, 64'b100000);
        check("reset_dut2", {61'd0, in_ready2, out_valid2, busy2}, 64'b100);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(32'd144, 16'd12, 17'd0, 1'b0, 0);
        run_op(32'd150, 16'd12, 17'd6, 1'b0, 0);
        run_op(32'd0, 16'd0, 17'd0, 1'b0, 0);
        run_op(32'hFFFF_FFFF, 16'hFFFF, 17'h1FFFE, 1'b0, 0);
        run_op(32'd99, 16'd9, 17'd18, 1'b0, 5);

        // Abort on the 7th CALC edge; nothing is pushed so any output would be flagged.
        radicand = 32'd1000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_to_idle", {61'd0, busy, out_valid, in_ready}, 64'b001);
        repeat (20) begin
            @(posedge clk); #1;
        end
        check("abort_no_result", 64'(out_valid), 64'd0);
        run_op(32'd1024, 16'd32, 17'd0, 1'b0, 0);

        // Reset in the middle of CALC discards the operand.
        radicand = 32'd150;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("midcalc_reset", {58'd0, in_ready, out_valid, busy, 1'b0, |root, |rem}, 64'b100000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(32'd625, 16'd25, 17'd0, 1'b0, 0);

        for (int i = 0; i < 12; i++) begin
            r32 = $urandom;
            rr  = isqrt_ref(r32);
            run_op(r32, rr, 17'(r32 - 32'(rr) * 32'(rr)), 1'b0, 0);
        end

`ifdef ISQRT_ROUND_EN
        run_op(32'd156, 16'd12, 17'd12, 1'b1, 0);
        run_op(32'd157, 16'd13, 17'd13, 1'b1, 0);
        run_op(32'hFFFF_FFFF, 16'hFFFF, 17'h1FFFE, 1'b1, 0);
        run_op(32'd157, 16'd12, 17'd13, 1'b0, 0);
`endif

        run_op2(16'd65535, 8'd255, 9'd510);
        run_op2(16'd150, 8'd12, 9'd6);
        run_op2(16'd0, 8'd0, 9'd0);
        run_op2(16'd1000, 8'd31, 9'd39);
        run_op2(16'd4, 8'd2, 9'd0);
        for (int i = 0; i < 8; i++) begin
            r32 = 32'($urandom_range(0, 65535));
            rr  = isqrt_ref(r32);
            run_op2(r32[15:0], rr[7:0], 9'(r32 - 32'(rr) * 32'(rr)));
        end

        repeat (4) begin
            @(posedge clk); #1;
        end
        check("dut1_queue_drained", 64'(q1.size()), 64'd0);
        check("dut2_queue_drained", 64'(q2.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
